// File: rtl/cos_job_sequencer_pkg.sv
// ============================================================================
// Module  : cos_job_sequencer_pkg
// Brief   : Shared types and constants for the cosine job sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cos_job_sequencer_pkg;

    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] TIMEOUT_RESULT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        STORE = 2'd3
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_result_fifo.sv
// ============================================================================
// Module  : seq_result_fifo
// Brief   : Synchronous result FIFO, power-of-two depth, registered count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            din,
    output logic [DATA_W-1:0]            dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/cos_job_sequencer.sv
// ============================================================================
// Module  : cos_job_sequencer
// Brief   : Issues one cosine job per operand, buffers results in a FIFO.
//           Optional WAIT timeout enabled by macro COS_SEQ_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cos_job_sequencer
    import cos_job_sequencer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    output logic              acc_start,
    output logic [DATA_W-1:0] acc_x,
    input  logic              acc_done,
    input  logic [DATA_W-1:0] acc_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(DEPTH+1);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic              run;
    logic              expire;
    logic              fifo_push;
    logic [DATA_W-1:0] fifo_din;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // run keeps in_ready low while reset is held and for no longer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run   <= 1'b0;
            acc_x <= '0;
        end else begin
            run <= 1'b1;
            if (in_valid && in_ready) acc_x <= in_x;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        acc_start = 1'b0;
        fifo_push = 1'b0;
        fifo_din  = acc_result;
        case (state)
            IDLE: begin
                in_ready = run && (fifo_count < CNT_W'(DEPTH));
                if (in_valid && in_ready) state_nxt = ISSUE;
            end
            ISSUE: begin
                acc_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (acc_done) begin
                    fifo_push = !fifo_full;
                    state_nxt = STORE;
                end else if (expire) begin
                    fifo_push = !fifo_full;
                    fifo_din  = TIMEOUT_RESULT;
                    state_nxt = STORE;
                end
            end
            STORE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef COS_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC+1);

    logic [TO_W-1:0] wait_cnt;
    logic            err_q;

    // wait_cnt equals (WAIT cycle number - 1), so expiry lands on cycle TIMEOUT_CYC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == WAIT) wait_cnt <= wait_cnt + TO_W'(1);
            else               wait_cnt <= '0;
            if (expire && !acc_done) err_q <= 1'b1;
        end
    end

    assign expire      = (state == WAIT) && (wait_cnt == TO_W'(TIMEOUT_CYC-1));
    assign err_timeout = err_q;
`else
    assign expire      = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign out_valid = !fifo_empty;

    seq_result_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (out_valid && out_ready),
        .din   (fifo_din),
        .dout  (out_data),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

`default_nettype wire

// File: tb/tb_cos_job_sequencer.sv
// ============================================================================
// Module  : tb_cos_job_sequencer
// Brief   : Directed, table-driven self-checking bench for cos_job_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cos_job_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic        acc_start;
    logic [15:0] acc_x;
    logic        acc_done = 1'b0;
    logic [15:0] acc_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] res;
        int          lat;
    } vec_t;

    vec_t vt [4];

    cos_job_sequencer #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .acc_start   (acc_start),
        .acc_x       (acc_x),
        .acc_done    (acc_done),
        .acc_result  (acc_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one operand, check the start pulse, return in STORE after done.
    task automatic do_job(input logic [15:0] x, input logic [15:0] res, input int lat,
                          input logic pre_valid);
        in_valid = 1'b1;
        in_x     = x;
        tick;
        in_valid = 1'b0;
        in_x     = 16'hDEAD;
        check("start_pulse", acc_start, 1);
        check("acc_x_issue", acc_x, x);
        check("ready_in_issue", in_ready, 0);
        tick;
        check("start_low_wait", acc_start, 0);
        repeat (lat - 1) tick;
        acc_done   = 1'b1;
        acc_result = res;
        check("acc_x_held", acc_x, x);
        check("valid_at_done", out_valid, pre_valid);
        tick;
        acc_done   = 1'b0;
        acc_result = '0;
    endtask

    initial begin
        vt[0] = '{16'h1234, 16'h7FFF, 10};
        vt[1] = '{16'h0000, 16'h0001, 1};
        vt[2] = '{16'hFFFF, 16'h8000, 3};
        vt[3] = '{16'hA5A5, 16'h5A5A, 2};

        // Reset
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_start", acc_start, 0);
        check("rst_acc_x", acc_x, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err_timeout, 0);
        rst = 1'b1;
        tick;
        check("post_rst_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);

        // done while IDLE must be ignored
        acc_done   = 1'b1;
        acc_result = 16'h1111;
        tick;
        acc_done = 1'b0;
        check("idle_done_ignored", out_valid, 0);
        check("idle_done_busy", busy, 0);

        // Table-driven single jobs
        for (int i = 0; i < 4; i++) begin
            check("pre_ready", in_ready, 1);
            do_job(vt[i].x, vt[i].res, vt[i].lat, 1'b0);
            check("valid_after_done", out_valid, 1);
            check("out_data", out_data, vt[i].res);
            check("store_busy", busy, 1);
            check("store_ready", in_ready, 0);
            tick;
            check("idle_busy", busy, 0);
            check("idle_ready", in_ready, 1);
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
            check("drained", out_valid, 0);
        end

        // Back-pressure: fill the FIFO with results 1..4
        for (int i = 1; i <= 4; i++) begin
            do_job(16'(i * 16), 16'(i), 2, (i > 1));
            tick;
            check("bp_ready", in_ready, 32'(i < 4));
        end
        in_valid = 1'b1;
        in_x     = 16'h0050;
        tick;
        check("bp_stall_start", acc_start, 0);
        check("bp_stall_busy", busy, 0);
        check("bp_head", out_data, 1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("bp_ready_after_pop", in_ready, 1);
        check("bp_head2", out_data, 2);
        tick;
        in_valid = 1'b0;
        check("bp5_start", acc_start, 1);
        check("bp5_acc_x", acc_x, 16'h0050);
        tick;
        acc_done   = 1'b1;
        acc_result = 16'd5;
        tick;
        acc_done = 1'b0;
        tick;
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check("bp_drain_valid", out_valid, 1);
            check("bp_drain_data", out_data, k);
            tick;
        end
        out_ready = 1'b0;
        check("bp_empty", out_valid, 0);

        // Simultaneous push and pop with two entries held
        do_job(16'h0101, 16'h000A, 1, 1'b0);
        tick;
        do_job(16'h0202, 16'h000B, 1, 1'b1);
        tick;
        in_valid = 1'b1;
        in_x     = 16'h0303;
        tick;
        in_valid = 1'b0;
        tick;
        acc_done   = 1'b1;
        acc_result = 16'h000C;
        out_ready  = 1'b1;
        check("pp_head_a", out_data, 16'h000A);
        tick;
        acc_done  = 1'b0;
        out_ready = 1'b0;
        check("pp_valid", out_valid, 1);
        check("pp_head_b", out_data, 16'h000B);
        tick;
        out_ready = 1'b1;
        tick;
        check("pp_valid_c", out_valid, 1);
        check("pp_head_c", out_data, 16'h000C);
        tick;
        out_ready = 1'b0;
        check("pp_count_two", out_valid, 0);

        // Reset mid-job with a stored result pending
        do_job(16'h0404, 16'h0044, 3, 1'b0);
        tick;
        check("mr_pending", out_valid, 1);
        in_valid = 1'b1;
        in_x     = 16'h0505;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        check("mr_in_wait", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_start", acc_start, 0);
        check("mr_acc_x", acc_x, 0);
        check("mr_flush", out_valid, 0);
        check("mr_ready", in_ready, 0);
        tick;
        rst = 1'b1;
        tick;
        check("mr_ready_after", in_ready, 1);
        acc_done   = 1'b1;
        acc_result = 16'h9999;
        tick;
        acc_done = 1'b0;
        check("mr_late_done", out_valid, 0);
        check("mr_idle", busy, 0);

`ifdef COS_SEQ_TIMEOUT_EN
        // Timeout with no done
        in_valid = 1'b1;
        in_x     = 16'h0606;
        tick;
        in_valid = 1'b0;
        tick;
        repeat (19) tick;
        check("to_not_yet", err_timeout, 0);
        check("to_still_wait", busy, 1);
        tick;
        check("to_err", err_timeout, 1);
        check("to_valid", out_valid, 1);
        check("to_data", out_data, 16'hFFFF);
        tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        check("to_err_cleared", err_timeout, 0);
        // done on the expiry cycle wins
        in_valid = 1'b1;
        in_x     = 16'h0707;
        tick;
        in_valid = 1'b0;
        tick;
        repeat (19) tick;
        acc_done   = 1'b1;
        acc_result = 16'h4321;
        tick;
        acc_done = 1'b0;
        check("to_tie_err", err_timeout, 0);
        check("to_tie_data", out_data, 16'h4321);
        check("to_tie_valid", out_valid, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
